reset_sequencer: RTL and testbench

//   Source end of the on-chip reset network: generates ordered, per-stage active-low resets
//   for the hash pipeline (I/O, message buffer, round cores, output) from one async reset.

---
 rtl/reset_sequencer.sv | 91 +++++++++
 tb/tb_reset_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset network source: holds every pipeline stage in reset, then releases the stages one at a time
// in order, and reruns that sequence when the host raises a 4-phase soft-reset request.
module reset_sequencer #(
    parameter int unsigned N_STAGES    = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                soft_req,
    output logic                soft_ack,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                all_ready
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ASSERT;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            stage_rst_n <= '0;
            all_ready   <= 1'b0;
            soft_ack    <= 1'b0;
        end else begin
            case (r_state)
                ASSERT: begin
                    if (r_cnt == HOLD_LAST) begin
                        stage_rst_n <= stage_rst_n | N_STAGES'(1);
                        r_state     <= RELEASE;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_idx != IDX_LAST) begin
                            // Shifting in ones keeps the released set a contiguous low-order run
                            stage_rst_n <= (stage_rst_n << 1) | N_STAGES'(1);
                            r_idx       <= r_idx + 1'b1;
                        end else begin
                            r_state   <= RUN;
                            all_ready <= 1'b1;
                            if (r_pending) begin
                                soft_ack  <= 1'b1;
                                r_pending <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (soft_req && !soft_ack) begin
                        stage_rst_n <= '0;
                        all_ready   <= 1'b0;
                        r_pending   <= 1'b1;
                        r_state     <= ASSERT;
                        r_cnt       <= '0;
                    end else if (!soft_req) begin
                        soft_ack <= 1'b0;
                    end
                end
                default: r_state <= ASSERT;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance A plus a minimal 1/1/1 instance B.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       soft_req_a, soft_ack_a, ready_a;
    logic [3:0] stage_a;
    logic       soft_req_b, soft_ack_b, ready_b;
    logic [0:0] stage_b;

    int n_cmp;
    int n_err;
    int ecount;

    typedef struct {
        int         off;
        logic [3:0] stage;
        logic       ready;
    } vec_t;

    vec_t tbl [10];

    reset_sequencer #(.N_STAGES(4), .HOLD_CYCLES(16), .GAP_CYCLES(8)) u_a (
        .clk         (clk),
        .reset       (reset),
        .soft_req    (soft_req_a),
        .soft_ack    (soft_ack_a),
        .stage_rst_n (stage_a),
        .all_ready   (ready_a)
    );

    reset_sequencer #(.N_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) u_b (
        .clk         (clk),
        .reset       (reset),
        .soft_req    (soft_req_b),
        .soft_ack    (soft_ack_b),
        .stage_rst_n (stage_b),
        .all_ready   (ready_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @E%0d: got %0h expected %0h", name, ecount, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic goto_edge(input int n);
        while (ecount < n) tick();
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        check("async_stage_a", stage_a, 4'b0000);
        check("async_ready_a", ready_a, 1'b0);
        check("async_ack_a", soft_ack_a, 1'b0);
        #1 reset = 1'b0;
        ecount = 0;
    endtask

    task automatic run_table(input int base, input bit ack_last);
        for (int i = 0; i < 10; i++) begin
            goto_edge(base + tbl[i].off);
            check("seq_stage", stage_a, tbl[i].stage);
            check("seq_ready", ready_a, tbl[i].ready);
            check("seq_ack", soft_ack_a, (ack_last && i == 9) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        int t;
        n_cmp = 0;
        n_err = 0;
        ecount = 0;
        tbl[0] = '{15, 4'b0000, 1'b0};
        tbl[1] = '{16, 4'b0001, 1'b0};
        tbl[2] = '{23, 4'b0001, 1'b0};
        tbl[3] = '{24, 4'b0011, 1'b0};
        tbl[4] = '{31, 4'b0011, 1'b0};
        tbl[5] = '{32, 4'b0111, 1'b0};
        tbl[6] = '{39, 4'b0111, 1'b0};
        tbl[7] = '{40, 4'b1111, 1'b0};
        tbl[8] = '{47, 4'b1111, 1'b0};
        tbl[9] = '{48, 4'b1111, 1'b1};

        // Power-on
        reset = 1'b1;
        soft_req_a = 1'b0;
        soft_req_b = 1'b0;
        #1;
        check("por_stage_a", stage_a, 4'b0000);
        check("por_ready_a", ready_a, 1'b0);
        check("por_stage_b", stage_b, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("por_hold_stage_a", stage_a, 4'b0000);
        reset = 1'b0;
        ecount = 0;
        goto_edge(1);
        check("b_e1_stage", stage_b, 1'b1);
        check("b_e1_ready", ready_b, 1'b0);
        goto_edge(2);
        check("b_e2_ready", ready_b, 1'b1);
        check("b_e2_ack", soft_ack_b, 1'b0);
        run_table(0, 1'b0);

        // Soft reset accepted at T = E51
        goto_edge(50);
        soft_req_a = 1'b1;
        goto_edge(51);
        check("soft_t_stage", stage_a, 4'b0000);
        check("soft_t_ready", ready_a, 1'b0);
        check("soft_t_ack", soft_ack_a, 1'b0);
        run_table(51, 1'b1);

        // Held request after ack: no retrigger
        for (int i = 0; i < 100; i++) begin
            tick();
            check("held_stage", stage_a, 4'b1111);
            check("held_ack", soft_ack_a, 1'b1);
        end
        soft_req_a = 1'b0;
        tick();
        check("drop_ack", soft_ack_a, 1'b0);
        check("drop_ready", ready_a, 1'b1);
        repeat (3) tick();
        check("drop_stage", stage_a, 4'b1111);

        // Reset mid-RELEASE during a soft sequence: request abandoned
        soft_req_a = 1'b1;
        t = ecount + 1;
        goto_edge(t + 28);
        check("mid_stage", stage_a, 4'b0011);
        soft_req_a = 1'b0;
        pulse_reset();
        run_table(0, 1'b0);

        // Early request held from E5
        pulse_reset();
        goto_edge(4);
        soft_req_a = 1'b1;
        goto_edge(47);
        check("early_e47_stage", stage_a, 4'b1111);
        check("early_e47_ready", ready_a, 1'b0);
        goto_edge(48);
        check("early_e48_ready", ready_a, 1'b1);
        check("early_e48_ack", soft_ack_a, 1'b0);
        goto_edge(49);
        check("early_e49_stage", stage_a, 4'b0000);
        check("early_e49_ready", ready_a, 1'b0);
        goto_edge(96);
        check("early_e96_ack", soft_ack_a, 1'b0);
        goto_edge(97);
        check("early_e97_ack", soft_ack_a, 1'b1);
        check("early_e97_ready", ready_a, 1'b1);
        soft_req_a = 1'b0;
        goto_edge(98);
        check("early_e98_ack", soft_ack_a, 1'b0);

        // Minimal instance soft reset
        soft_req_b = 1'b1;
        t = ecount + 1;
        goto_edge(t);
        check("b_soft_t_stage", stage_b, 1'b0);
        check("b_soft_t_ready", ready_b, 1'b0);
        goto_edge(t + 1);
        check("b_soft_t1_stage", stage_b, 1'b1);
        check("b_soft_t1_ack", soft_ack_b, 1'b0);
        goto_edge(t + 2);
        check("b_soft_t2_ready", ready_b, 1'b1);
        check("b_soft_t2_ack", soft_ack_b, 1'b1);
        soft_req_b = 1'b0;
        tick();
        check("b_drop_ack", soft_ack_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
